// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the bundle of stage-register load/flush controls.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HUNG     = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic mem_wb_load;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // Canned control words for each priority branch.
  localparam pipe_ctrl_t PIPE_HOLD     = pipe_ctrl_t'(7'b00000_00);
  localparam pipe_ctrl_t PIPE_REDIRECT = pipe_ctrl_t'(7'b11111_11);
  localparam pipe_ctrl_t PIPE_BUBBLE   = pipe_ctrl_t'(7'b00111_01);
  localparam pipe_ctrl_t PIPE_NORMAL   = pipe_ctrl_t'(7'b11111_00);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-relevant pipeline fields and memory handshakes in, stage register
// load/flush controls out. The controller uses the slave modport.
interface pipeline_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_valid;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_redirect;
  logic       imem_read;
  logic       imem_resp;
  logic       dmem_req;
  logic       dmem_resp;
  logic       pc_load;
  logic       if_id_load;
  logic       id_ex_load;
  logic       ex_mem_load;
  logic       mem_wb_load;
  logic       if_id_flush;
  logic       id_ex_flush;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_valid, ex_mem_read, ex_rd, ex_redirect,
    output imem_read, imem_resp, dmem_req, dmem_resp,
    input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
    input  if_id_flush, id_ex_flush
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_valid, ex_mem_read, ex_rd, ex_redirect,
    input  imem_read, imem_resp, dmem_req, dmem_resp,
    output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
    output if_id_flush, id_ex_flush
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, with hazard
// performance counters and a memory-hang watchdog.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic                 hang_o
);

  localparam int WD_W = $clog2(WDOG_LIMIT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_LIMIT - 1);

  hazard_state_t   state_q;
  hazard_state_t   state_d;
  logic            hang_q;
  logic            hang_d;
  logic            mem_stall_s;
  logic            load_use_s;
  logic            redirect_taken_s;
  logic            bubble_taken_s;
  logic            wdog_clr_s;
  logic [WD_W-1:0] wdog_cnt_s;
  pipe_ctrl_t      ctrl_s;

  assign mem_stall_s = (hz.imem_read & ~hz.imem_resp) | (hz.dmem_req & ~hz.dmem_resp);

  assign load_use_s = hz.id_valid & hz.ex_valid & hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                      ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

  // Priority select of the stage controls; everything frozen while in reset.
  always_comb begin
    ctrl_s           = PIPE_NORMAL;
    redirect_taken_s = 1'b0;
    bubble_taken_s   = 1'b0;
    if (!rst) begin
      ctrl_s = PIPE_HOLD;
    end else if (mem_stall_s) begin
      ctrl_s = PIPE_HOLD;
    end else if (hz.ex_redirect) begin
      ctrl_s           = PIPE_REDIRECT;
      redirect_taken_s = 1'b1;
    end else if (load_use_s) begin
      ctrl_s         = PIPE_BUBBLE;
      bubble_taken_s = 1'b1;
    end else begin
      ctrl_s = PIPE_NORMAL;
    end
  end

  assign hz.pc_load     = ctrl_s.pc_load;
  assign hz.if_id_load  = ctrl_s.if_id_load;
  assign hz.id_ex_load  = ctrl_s.id_ex_load;
  assign hz.ex_mem_load = ctrl_s.ex_mem_load;
  assign hz.mem_wb_load = ctrl_s.mem_wb_load;
  assign hz.if_id_flush = ctrl_s.if_id_flush;
  assign hz.id_ex_flush = ctrl_s.id_ex_flush;

  // Next-state and sticky hang flag; leaving a stall never costs a dead cycle.
  always_comb begin
    state_d = state_q;
    hang_d  = hang_q;
    case (state_q)
      RUN: begin
        if (mem_stall_s) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall_s) begin
          state_d = RUN;
        end else if (wdog_cnt_s == WD_LAST) begin
          state_d = HUNG;
          hang_d  = 1'b1;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      HUNG: begin
        if (!mem_stall_s) begin
          state_d = RUN;
        end else begin
          state_d = HUNG;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and hang flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hang_q  <= hang_d;
    end
  end

  // The watchdog counts every consecutive stall cycle, including the one that
  // leaves RUN, so the limit equals the number of stalled cycles before HUNG.
  assign wdog_clr_s = ~mem_stall_s;

  sat_counter #(.W(WD_W)) u_wdog (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (wdog_clr_s),
    .inc_i (mem_stall_s),
    .cnt_o (wdog_cnt_s)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (1'b0),
    .inc_i (mem_stall_s),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (1'b0),
    .inc_i (bubble_taken_s),
    .cnt_o (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (1'b0),
    .inc_i (redirect_taken_s),
    .cnt_o (flush_cnt)
  );

  assign state_o = state_q;
  assign hang_o  = hang_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (watchdog limit 8).
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;
  logic        hang_o;
  logic [6:0]  ctl;
  int          pass_cnt;
  int          fail_cnt;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.CNT_W(32), .WDOG_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .hz         (bus),
    .state_o    (state_o),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt),
    .hang_o     (hang_o)
  );

  // {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id flush, id_ex flush}
  assign ctl = {bus.pc_load, bus.if_id_load, bus.id_ex_load, bus.ex_mem_load,
                bus.mem_wb_load, bus.if_id_flush, bus.id_ex_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.id_valid    = 1'b0;
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_redirect = 1'b0;
    bus.imem_read   = 1'b0;
    bus.imem_resp   = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_resp   = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus.id_valid    = 1'b1;
    bus.id_rs1      = rd;
    bus.id_use_rs1  = 1'b1;
    bus.ex_valid    = 1'b1;
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = rd;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    if (ctl !== 7'b0000000) begin fail_cnt++; $display("FAIL rst_held_ctl: got %b expected %b", ctl, 7'b0000000); end else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    if (state_o !== 2'd0) begin fail_cnt++; $display("FAIL rst_state: got %0d expected 0", state_o); end else pass_cnt++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== 96'd0) begin fail_cnt++; $display("FAIL rst_counters: got %0d %0d %0d expected 0 0 0", stall_cnt, bubble_cnt, flush_cnt); end else pass_cnt++;
    if (hang_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_hang: got %b expected 0", hang_o); end else pass_cnt++;
    if (ctl !== 7'b1111100) begin fail_cnt++; $display("FAIL rst_idle_ctl: got %b expected %b", ctl, 7'b1111100); end else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #1;
    if (ctl !== 7'b0011101) begin fail_cnt++; $display("FAIL lu_ctl: got %b expected %b", ctl, 7'b0011101); end else pass_cnt++;
    next_cycle();
    if (bubble_cnt !== 32'd1) begin fail_cnt++; $display("FAIL lu_bubble_cnt: got %0d expected 1", bubble_cnt); end else pass_cnt++;
    // The load has moved on; EX now holds the bubble.
    bus.ex_valid    = 1'b0;
    bus.ex_mem_read = 1'b0;
    #1;
    if (ctl !== 7'b1111100) begin fail_cnt++; $display("FAIL lu_after_ctl: got %b expected %b", ctl, 7'b1111100); end else pass_cnt++;
    next_cycle();
    if (bubble_cnt !== 32'd1) begin fail_cnt++; $display("FAIL lu_after_cnt: got %0d expected 1", bubble_cnt); end else pass_cnt++;
    // rs2 match also bubbles.
    bus.id_rs1      = 5'd1;
    bus.id_rs2      = 5'd9;
    bus.id_use_rs2  = 1'b1;
    bus.ex_valid    = 1'b1;
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd9;
    #1;
    if (ctl !== 7'b0011101) begin fail_cnt++; $display("FAIL lu_rs2_ctl: got %b expected %b", ctl, 7'b0011101); end else pass_cnt++;
    next_cycle();
    if (bubble_cnt !== 32'd2) begin fail_cnt++; $display("FAIL lu_rs2_cnt: got %0d expected 2", bubble_cnt); end else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    set_load_use(5'd5);
    bus.ex_redirect = 1'b1;
    #1;
    if (ctl !== 7'b1111111) begin fail_cnt++; $display("FAIL redir_ctl: got %b expected %b", ctl, 7'b1111111); end else pass_cnt++;
    next_cycle();
    if (flush_cnt !== 32'd1) begin fail_cnt++; $display("FAIL redir_flush_cnt: got %0d expected 1", flush_cnt); end else pass_cnt++;
    if (bubble_cnt !== 32'd0) begin fail_cnt++; $display("FAIL redir_bubble_cnt: got %0d expected 0", bubble_cnt); end else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_dmem_stall();
    do_reset();
    bus.dmem_req    = 1'b1;
    bus.ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ctl !== 7'b0000000) begin fail_cnt++; $display("FAIL dstall_ctl[%0d]: got %b expected %b", i, ctl, 7'b0000000); end else pass_cnt++;
      next_cycle();
      if (state_o !== 2'd1) begin fail_cnt++; $display("FAIL dstall_state[%0d]: got %0d expected 1", i, state_o); end else pass_cnt++;
    end
    if (stall_cnt !== 32'd4) begin fail_cnt++; $display("FAIL dstall_cnt: got %0d expected 4", stall_cnt); end else pass_cnt++;
    if (flush_cnt !== 32'd0) begin fail_cnt++; $display("FAIL dstall_flush_held: got %0d expected 0", flush_cnt); end else pass_cnt++;
    bus.dmem_resp = 1'b1;
    #1;
    if (ctl !== 7'b1111111) begin fail_cnt++; $display("FAIL dresp_ctl: got %b expected %b", ctl, 7'b1111111); end else pass_cnt++;
    next_cycle();
    if (state_o !== 2'd0) begin fail_cnt++; $display("FAIL dresp_state: got %0d expected 0", state_o); end else pass_cnt++;
    if (flush_cnt !== 32'd1) begin fail_cnt++; $display("FAIL dresp_flush_cnt: got %0d expected 1", flush_cnt); end else pass_cnt++;
    if (stall_cnt !== 32'd4) begin fail_cnt++; $display("FAIL dresp_stall_cnt: got %0d expected 4", stall_cnt); end else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    do_reset();
    set_load_use(5'd0);
    #1;
    if (ctl !== 7'b1111100) begin fail_cnt++; $display("FAIL rd0_ctl: got %b expected %b", ctl, 7'b1111100); end else pass_cnt++;
    next_cycle();
    if (bubble_cnt !== 32'd0) begin fail_cnt++; $display("FAIL rd0_bubble_cnt: got %0d expected 0", bubble_cnt); end else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_dual_stall();
    do_reset();
    bus.imem_read = 1'b1;
    bus.dmem_req  = 1'b1;
    repeat (2) next_cycle();
    if (stall_cnt !== 32'd2) begin fail_cnt++; $display("FAIL dual_stall_cnt: got %0d expected 2", stall_cnt); end else pass_cnt++;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.imem_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ctl !== 7'b0000000) begin fail_cnt++; $display("FAIL wd_ctl[%0d]: got %b expected %b", i, ctl, 7'b0000000); end else pass_cnt++;
      next_cycle();
      if (state_o !== ((i >= 7) ? 2'd2 : 2'd1)) begin fail_cnt++; $display("FAIL wd_state[%0d]: got %0d expected %0d", i, state_o, ((i >= 7) ? 2 : 1)); end else pass_cnt++;
      if (hang_o !== (i >= 7)) begin fail_cnt++; $display("FAIL wd_hang[%0d]: got %b expected %b", i, hang_o, (i >= 7)); end else pass_cnt++;
    end
    if (stall_cnt !== 32'd10) begin fail_cnt++; $display("FAIL wd_stall_cnt: got %0d expected 10", stall_cnt); end else pass_cnt++;
    bus.imem_resp = 1'b1;
    #1;
    if (ctl !== 7'b1111100) begin fail_cnt++; $display("FAIL wd_resp_ctl: got %b expected %b", ctl, 7'b1111100); end else pass_cnt++;
    next_cycle();
    idle_inputs();
    if (state_o !== 2'd0) begin fail_cnt++; $display("FAIL wd_resp_state: got %0d expected 0", state_o); end else pass_cnt++;
    repeat (3) next_cycle();
    if (hang_o !== 1'b1) begin fail_cnt++; $display("FAIL wd_hang_sticky: got %b expected 1", hang_o); end else pass_cnt++;
    do_reset();
    #1;
    if (hang_o !== 1'b0) begin fail_cnt++; $display("FAIL wd_hang_cleared: got %b expected 0", hang_o); end else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.dmem_req = 1'b1;
    repeat (3) next_cycle();
    #2;
    rst = 1'b0;
    #1;
    if (state_o !== 2'd0) begin fail_cnt++; $display("FAIL midrst_state: got %0d expected 0", state_o); end else pass_cnt++;
    if (stall_cnt !== 32'd0) begin fail_cnt++; $display("FAIL midrst_stall_cnt: got %0d expected 0", stall_cnt); end else pass_cnt++;
    if (ctl !== 7'b0000000) begin fail_cnt++; $display("FAIL midrst_ctl: got %b expected %b", ctl, 7'b0000000); end else pass_cnt++;
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
  endtask

  initial begin
    pass_cnt = 0;
    fail_cnt = 0;
    rst      = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_redirect_load_use();
    test_dmem_stall();
    test_rd_zero();
    test_dual_stall();
    test_watchdog();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
